// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
// Holds the fetch FSM encoding and the prefetch buffer entry layout.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush and an occupancy count.
// Push and pop may coincide at any occupancy, including full.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Storage is cleared on reset so the read port shows zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited memory reads,
// buffers in-order responses with their PCs and squashes stale fetches on redirect.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [XLEN-1:0]    instr_pc,
  output logic               align_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e     state, state_n;
  logic [XLEN-1:0]  fetch_pc, fetch_pc_n;
  logic [XLEN-1:0]  rsp_pc, rsp_pc_n;
  logic [XLEN-1:0]  target_pc;
  logic [CNT_W-1:0] outstanding, outstanding_n;
  logic [CNT_W-1:0] drop_cnt, drop_cnt_n;
  logic [CNT_W-1:0] fifo_count, fifo_count_n;
  logic             req_fire, push, pop;
  logic             req_valid_n, align_err_n;
  logic             fifo_full, fifo_empty;
  fetch_entry_t     push_entry, head_entry;
  logic [ENTRY_W-1:0] fifo_rdata;

  assign imem_req_addr = fetch_pc;
  assign instr_valid   = !fifo_empty;
  assign head_entry    = fetch_entry_t'(fifo_rdata);
  assign instr_data    = head_entry.instr;
  assign instr_pc      = head_entry.pc;

  // Next-state, counter and request-credit computation.
  always_comb begin
    state_n       = state;
    target_pc     = {redirect_pc[XLEN-1:2], 2'b00};
    req_fire      = imem_req_valid && imem_req_ready;
    pop           = instr_valid && instr_ready;
    push          = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    push_entry    = '{instr: imem_rsp_data, pc: rsp_pc};
    outstanding_n = outstanding + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    drop_cnt_n    = drop_cnt;
    fetch_pc_n    = fetch_pc;
    rsp_pc_n      = rsp_pc;
    fifo_count_n  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    align_err_n   = 1'b0;

    if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt_n = drop_cnt - CNT_W'(1);
    if (req_fire) fetch_pc_n = fetch_pc + XLEN'(4);
    if (push)     rsp_pc_n   = rsp_pc + XLEN'(4);

    // Everything in flight, including this cycle's accepted request, becomes stale.
    if (redirect_valid) begin
      drop_cnt_n   = outstanding_n;
      fetch_pc_n   = target_pc;
      rsp_pc_n     = target_pc;
      fifo_count_n = '0;
      align_err_n  = (redirect_pc[1:0] != 2'b00);
    end

    case (state)
      S_BOOT:  state_n = S_RUN;
      S_RUN:   if (halt_req) state_n = S_HALT;
      S_HALT:  if (redirect_valid) state_n = S_RUN;
      default: state_n = S_BOOT;
    endcase

    // Registered form of: in RUN and outstanding + buffered below DEPTH.
    req_valid_n = (state_n == S_RUN) &&
                  ((SUM_W'(outstanding_n) + SUM_W'(fifo_count_n)) < SUM_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_BOOT;
      fetch_pc       <= {RESET_PC[XLEN-1:2], 2'b00};
      rsp_pc         <= {RESET_PC[XLEN-1:2], 2'b00};
      outstanding    <= '0;
      drop_cnt       <= '0;
      imem_req_valid <= 1'b0;
      align_err      <= 1'b0;
    end else begin
      state          <= state_n;
      fetch_pc       <= fetch_pc_n;
      rsp_pc         <= rsp_pc_n;
      outstanding    <= outstanding_n;
      drop_cnt       <= drop_cnt_n;
      imem_req_valid <= req_valid_n;
      align_err      <= align_err_n;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Credit accounting must make a push into a full, non-draining buffer impossible.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: cycle-stepped memory and decode model with a
// transaction-level expectation of request addresses and delivered PCs.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk, rst_n;
  logic imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic redirect_valid;
  logic [31:0] redirect_pc;
  logic halt_req;
  logic instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic align_err;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .align_err(align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  mreq_t       memq[$];
  logic [31:0] pop_log[$];
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, lat_min = 1, lat_max = 1, rdy_pct = 100, dec_pct = 100;
  int buffered = 0, drop = 0, n_req = 0, n_pop = 0, first_valid_cyc = -1;
  bit halt_lvl = 0, redir_go = 0, exp_align = 0;
  logic [31:0] redir_tgt = 0, exp_pc = 0, exp_req = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // One clock cycle: drive inputs at the falling edge, then account for the handshakes.
  task automatic step();
    logic exp_v;
    mreq_t m;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    instr_ready    = ($urandom_range(99) < dec_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (memq.size() > 0) begin
      if (memq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(memq[0].addr);
      end
    end
    redirect_valid = redir_go;
    redirect_pc    = redir_go ? redir_tgt : $urandom;
    halt_req       = halt_lvl;
    #1;
    exp_v = (buffered > 0);
    n_cmp++;
    if (instr_valid !== exp_v) begin
      n_fail++; $display("FAIL instr_valid cyc=%0d: got %b expected %b", cyc, instr_valid, exp_v);
    end
    n_cmp++;
    if (align_err !== exp_align) begin
      n_fail++; $display("FAIL align_err cyc=%0d: got %b expected %b", cyc, align_err, exp_align);
    end
    if (instr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (instr_valid === 1'b1 && instr_ready) begin
      n_cmp++;
      if (instr_pc !== exp_pc) begin
        n_fail++; $display("FAIL instr_pc cyc=%0d: got %h expected %h", cyc, instr_pc, exp_pc);
      end
      n_cmp++;
      if (instr_data !== mem_word(exp_pc)) begin
        n_fail++; $display("FAIL instr_data cyc=%0d: got %h expected %h", cyc, instr_data, mem_word(exp_pc));
      end
      pop_log.push_back(instr_pc);
      exp_pc = exp_pc + 32'd4;
      buffered--;
      n_pop++;
    end
    if (imem_rsp_valid) begin
      void'(memq.pop_front());
      if (drop > 0) drop--;
      else if (!redir_go) buffered++;
    end
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      n_cmp++;
      if (imem_req_addr !== exp_req) begin
        n_fail++; $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, exp_req);
      end
      m.addr = imem_req_addr;
      m.due  = cyc + int'($urandom_range(lat_max, lat_min));
      memq.push_back(m);
      exp_req = exp_req + 32'd4;
      n_req++;
    end
    if (redir_go) begin
      buffered  = 0;
      drop      = memq.size();
      exp_pc    = {redir_tgt[31:2], 2'b00};
      exp_req   = {redir_tgt[31:2], 2'b00};
      exp_align = (redir_tgt[1:0] != 2'b00);
    end else begin
      exp_align = 1'b0;
    end
    n_cmp++;
    if (memq.size() + buffered > DEPTH) begin
      n_fail++; $display("FAIL credit cyc=%0d: got %0d in use expected <= %0d", cyc, memq.size() + buffered, DEPTH);
    end
    redir_go = 1'b0;
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redir_tgt = t;
    redir_go  = 1'b1;
    step();
  endtask

  task automatic wait_pops(input int target, input int budget, input string what);
    int b = budget;
    while (n_pop < target && b > 0) begin step(); b--; end
    n_cmp++;
    if (n_pop < target) begin
      n_fail++; $display("FAIL %s timeout: got %0d pops expected %0d", what, n_pop, target);
    end
  endtask

  task automatic wait_outstanding(input int n, input int budget, input string what);
    int b = budget;
    while (memq.size() != n && b > 0) begin step(); b--; end
    n_cmp++;
    if (memq.size() != n) begin
      n_fail++; $display("FAIL %s timeout: got %0d outstanding expected %0d", what, memq.size(), n);
    end
  endtask

  task automatic check_pop(input int idx, input logic [31:0] e, input string what);
    logic [31:0] got;
    got = (idx < pop_log.size()) ? pop_log[idx] : 32'hDEAD_BEEF;
    n_cmp++;
    if (got !== e) begin
      n_fail++; $display("FAIL %s: got %h expected %h", what, got, e);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; halt_req = 0; instr_ready = 0;
    memq.delete(); pop_log.delete();
    buffered = 0; drop = 0; n_req = 0; n_pop = 0; first_valid_cyc = -1;
    halt_lvl = 0; redir_go = 0; exp_align = 0;
    exp_pc = RST_PC; exp_req = RST_PC;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst req_valid: got %b expected 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL rst req_addr: got %h expected %h", imem_req_addr, RST_PC); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst instr_valid: got %b expected 0", instr_valid); end
    n_cmp++; if (instr_data !== 32'h0) begin n_fail++; $display("FAIL rst instr_data: got %h expected 0", instr_data); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst instr_pc: got %h expected 0", instr_pc); end
    n_cmp++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL rst align_err: got %b expected 0", align_err); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 1;
  endtask

  task automatic test_boot();
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100;
    test_reset();
    for (int i = 0; i < 14; i++) begin
      if (cyc == 1) begin
        n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL boot cyc1 req_valid: got %b expected 0", imem_req_valid); end
      end
      if (cyc == 2) begin
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL boot cyc2 req_valid: got %b expected 1", imem_req_valid); end
      end
      step();
    end
    n_cmp++; if (first_valid_cyc != 4) begin n_fail++; $display("FAIL boot first_valid: got cycle %0d expected 4", first_valid_cyc); end
    n_cmp++; if (n_pop != 11) begin n_fail++; $display("FAIL boot throughput: got %0d pops expected 11", n_pop); end
    check_pop(0, 32'h0, "boot pc0");
    check_pop(1, 32'h4, "boot pc1");
    check_pop(2, 32'h8, "boot pc2");
  endtask

  task automatic test_back_pressure();
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 0;
    test_reset();
    run(12);
    n_cmp++; if (n_req != DEPTH) begin n_fail++; $display("FAIL bp requests: got %0d expected %0d", n_req, DEPTH); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp req_valid: got %b expected 0", imem_req_valid); end
    dec_pct = 100;
    wait_pops(DEPTH, 20, "bp drain");
    check_pop(0, 32'h0, "bp pc0");
    check_pop(3, 32'hC, "bp pc3");
    run(6);
  endtask

  task automatic test_redirect_inflight();
    int mark;
    lat_min = 3; lat_max = 3; rdy_pct = 100; dec_pct = 100;
    test_reset();
    run(8);
    wait_outstanding(3, 20, "inflight setup");
    redirect_to(32'h40);
    mark = n_pop;
    wait_pops(mark + 2, 30, "inflight pops");
    check_pop(mark, 32'h40, "inflight first pc");
    check_pop(mark + 1, 32'h44, "inflight second pc");
  endtask

  task automatic test_misaligned();
    int mark;
    lat_min = 1; lat_max = 2; rdy_pct = 100; dec_pct = 100;
    run(3);
    redirect_to(32'h42);
    n_cmp++; if (align_err !== 1'b1) begin n_fail++; $display("FAIL misalign pulse: got %b expected 1", align_err); end
    mark = n_pop;
    step();
    n_cmp++; if (align_err !== 1'b0) begin n_fail++; $display("FAIL misalign width: got %b expected 0", align_err); end
    wait_pops(mark + 1, 20, "misalign pops");
    check_pop(mark, 32'h40, "misalign resume pc");
  endtask

  task automatic test_halt();
    int mark, req_mark;
    lat_min = 2; lat_max = 2; rdy_pct = 100; dec_pct = 100;
    test_reset();
    run(6);
    wait_outstanding(2, 20, "halt setup");
    mark = n_pop;
    halt_lvl = 1'b1;
    step();
    req_mark = n_req;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) halt_lvl = 1'b0;
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL halt req_valid cyc=%0d: got %b expected 0", cyc, imem_req_valid); end
      step();
    end
    n_cmp++; if (n_pop - mark < 2) begin n_fail++; $display("FAIL halt drained: got %0d pops expected >= 2", n_pop - mark); end
    n_cmp++; if (n_req != req_mark) begin n_fail++; $display("FAIL halt new requests: got %0d expected 0", n_req - req_mark); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt empty: got %b expected 0", instr_valid); end
    redirect_to(32'h100);
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL halt resume req_valid: got %b expected 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL halt resume addr: got %h expected 100", imem_req_addr); end
    mark = n_pop;
    wait_pops(mark + 1, 20, "halt resume pops");
    check_pop(mark, 32'h100, "halt resume pc");
  endtask

  task automatic test_wrap();
    int mark;
    lat_min = 1; lat_max = 3; rdy_pct = 100; dec_pct = 100;
    redirect_to(32'hFFFF_FFF8);
    mark = n_pop;
    wait_pops(mark + 3, 40, "wrap pops");
    check_pop(mark, 32'hFFFF_FFF8, "wrap pc0");
    check_pop(mark + 1, 32'hFFFF_FFFC, "wrap pc1");
    check_pop(mark + 2, 32'h0000_0000, "wrap pc2");
  endtask

  task automatic test_back_to_back();
    int b, req_mark;
    bit hit;
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100;
    b = 30; hit = 0;
    while (!hit && b > 0) begin
      if (instr_valid === 1'b1 && imem_req_valid === 1'b1 && memq.size() > 0) begin
        if (memq[0].due <= cyc) hit = 1;
      end
      if (!hit) begin step(); b--; end
    end
    n_cmp++; if (!hit) begin n_fail++; $display("FAIL collision setup: got no aligned cycle expected one"); end
    redirect_to(32'h200);
    run(8);
    halt_lvl = 1'b1;
    step();
    halt_lvl = 1'b0;
    b = 20;
    while ((memq.size() != 0 || instr_valid !== 1'b0) && b > 0) begin step(); b--; end
    n_cmp++; if (memq.size() != 0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL collision idle: got %0d outstanding expected 0", memq.size()); end
    dec_pct = 0;
    req_mark = n_req;
    redirect_to(32'h300);
    run(10);
    n_cmp++; if (n_req - req_mark != DEPTH) begin n_fail++; $display("FAIL credits restored: got %0d requests expected %0d", n_req - req_mark, DEPTH); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL credits stop: got %b expected 0", imem_req_valid); end
    dec_pct = 100;
    run(10);
  endtask

  task automatic test_random();
    int mark;
    lat_min = 1; lat_max = 4; rdy_pct = 70; dec_pct = 60;
    for (int i = 0; i < 400; i++) begin
      halt_lvl = ($urandom_range(99) < 3);
      if ($urandom_range(99) < 5) begin
        redir_tgt = $urandom;
        if ($urandom_range(3) != 0) redir_tgt[1:0] = 2'b00;
        redir_go = 1'b1;
      end
      step();
    end
    halt_lvl = 1'b0; rdy_pct = 100; dec_pct = 100;
    redirect_to(32'h1000);
    mark = n_pop;
    wait_pops(mark + 8, 60, "random progress");
    check_pop(mark, 32'h1000, "random final pc");
  endtask

  task automatic test_reset_mid();
    lat_min = 2; lat_max = 3; rdy_pct = 100; dec_pct = 100;
    run(7);
    lat_min = 1; lat_max = 1;
    test_reset();
    run(10);
    n_cmp++; if (first_valid_cyc != 4) begin n_fail++; $display("FAIL reset mid first_valid: got cycle %0d expected 4", first_valid_cyc); end
    check_pop(0, RST_PC, "reset mid pc0");
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; halt_req = 0; instr_ready = 0;
    test_boot();
    test_back_pressure();
    test_redirect_inflight();
    test_misaligned();
    test_halt();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
